// File: rtl/mseq_manchester_tx_pkg.sv
// Shared definitions for the m-sequence Manchester transmitter: line-code
// polarity, bit phase states and default LFSR taps/seeds per register width.
package mseq_manchester_tx_pkg;

  // IEEE 802.3 polarity: a 1 is sent low-then-high
  localparam logic MANCH_ONE_FIRST = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } phase_t;

  function automatic logic [31:0] default_poly(input int width);
    case (width)
      4:       return 32'h0000_0009;
      8:       return 32'h0000_00B8;
      15:      return 32'h0000_6000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] default_seed(input int width);
    return (width > 0) ? 32'h0000_0001 : 32'h0000_0000;
  endfunction

endpackage

// File: rtl/mseq_manchester_tx_lfsr_gen.sv
// Fibonacci LFSR that advances one bit per step; an all-zero state (only
// reachable through an upset) is replaced by the seed so the stream never sticks.
module lfsr_gen #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(8'hB8),
  parameter logic [W-1:0]   SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] state,
  output logic         out_bit
);

  logic [W-1:0] src;

  assign src     = (state == '0) ? SEED : state;
  assign out_bit = src[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (step) begin
      state <= {src[W-2:0], ^(src & POLY)};
    end
  end

endmodule

// File: rtl/mseq_manchester_tx.sv
// Programmable-rate m-sequence transmitter with optional Manchester coding,
// plus a reference bit clock and a once-per-period frame marker.
module mseq_manchester_tx
  import mseq_manchester_tx_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 8,
  parameter logic [LFSR_WIDTH-1:0] POLY         = LFSR_WIDTH'(default_poly(LFSR_WIDTH)),
  parameter logic [LFSR_WIDTH-1:0] SEED         = LFSR_WIDTH'(default_seed(LFSR_WIDTH)),
  parameter int                    DIV_WIDTH    = 16,
  parameter int                    DEFAULT_HALF = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [DIV_WIDTH-1:0] rate_div,
  input  logic                 rate_load,
  input  logic                 manch_en,
  output logic                 data_out,
  output logic                 nrz_out,
  output logic                 bit_clk,
  output logic                 frame_start,
  output logic                 busy
);

  phase_t                phase, phase_next;
  logic [DIV_WIDTH-1:0]  half_len, half_cnt, pend_val;
  logic                  pend_valid, mode, cur_bit, load, last_half;
  logic [LFSR_WIDTH-1:0] lfsr;

  lfsr_gen #(
    .W    (LFSR_WIDTH),
    .POLY (POLY),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step    (load),
    .state   (lfsr),
    .out_bit (cur_bit)
  );

  assign last_half = (half_cnt == half_len - DIV_WIDTH'(1));

  always_comb begin
    phase_next = phase;
    load       = 1'b0;
    if (ena) begin
      case (phase)
        IDLE:    begin load = 1'b1; phase_next = FIRST; end
        FIRST:   if (last_half) phase_next = SECOND;
        SECOND:  if (last_half) begin load = 1'b1; phase_next = FIRST; end
        default: phase_next = IDLE;
      endcase
    end
  end

  // A pending rate only takes effect at a bit load; a strobe on the load cycle itself waits a bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= IDLE;
      half_len    <= DIV_WIDTH'(DEFAULT_HALF);
      half_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_val    <= '0;
      mode        <= 1'b0;
      data_out    <= 1'b0;
      nrz_out     <= 1'b0;
      bit_clk     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      phase       <= phase_next;
      frame_start <= 1'b0;
      if (load && pend_valid) begin
        half_len   <= pend_val;
        pend_valid <= 1'b0;
      end
      if (rate_load) begin
        pend_valid <= 1'b1;
        pend_val   <= (rate_div == '0) ? DIV_WIDTH'(1) : rate_div;
      end
      if (load) begin
        half_cnt    <= '0;
        nrz_out     <= cur_bit;
        bit_clk     <= 1'b1;
        busy        <= 1'b1;
        mode        <= manch_en;
        data_out    <= manch_en ? (cur_bit ? MANCH_ONE_FIRST : ~MANCH_ONE_FIRST) : cur_bit;
        frame_start <= (lfsr == SEED) || (lfsr == '0);
      end else if (ena && phase != IDLE) begin
        if (last_half) begin
          half_cnt <= '0;
          if (phase == FIRST) begin
            bit_clk  <= 1'b0;
            data_out <= mode ? (nrz_out ? ~MANCH_ONE_FIRST : MANCH_ONE_FIRST) : nrz_out;
          end
        end else begin
          half_cnt <= half_cnt + DIV_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mseq_manchester_tx.sv
// Directed bench for mseq_manchester_tx using a 4-bit LFSR (taps 4'h9, seed 1)
// so the full 15-bit m-sequence can be written out by hand.
module tb_mseq_manchester_tx;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] rate_div;
  logic        rate_load;
  logic        manch_en;
  logic        data_out;
  logic        nrz_out;
  logic        bit_clk;
  logic        frame_start;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Hand-derived stream for x^4 taps 4'h9 starting from state 4'b0001
  bit seq [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  mseq_manchester_tx #(
    .LFSR_WIDTH   (4),
    .POLY         (4'h9),
    .SEED         (4'h1),
    .DIV_WIDTH    (16),
    .DEFAULT_HALF (500)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .rate_div    (rate_div),
    .rate_load   (rate_load),
    .manch_en    (manch_en),
    .data_out    (data_out),
    .nrz_out     (nrz_out),
    .bit_clk     (bit_clk),
    .frame_start (frame_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_dut();
    @(negedge clk);
    ena       = 1'b0;
    rate_load = 1'b0;
    manch_en  = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] half, input logic manch);
    @(negedge clk);
    rate_div  = half;
    rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
    manch_en  = manch;
    ena       = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; rate_div = '0; rate_load = 1'b0; manch_en = 1'b0;
    #1;
    checks++; if (data_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_out got=%b exp=0", data_out); end
    checks++; if (nrz_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_nrz_out got=%b exp=0", nrz_out); end
    checks++; if (bit_clk !== 1'b0) begin failures++; $display("[TB] FAIL reset_bit_clk got=%b exp=0", bit_clk); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_nrz_stream();
    int i, ph;
    logic b;
    reset_dut();
    start_run(16'd2, 1'b0);
    for (int m = 0; m < 128; m++) begin
      @(negedge clk);
      i = m / 4; ph = m % 4; b = seq[i % 15];
      checks++; if (nrz_out !== b) begin failures++; $display("[TB] FAIL nrz_nrz m=%0d got=%b exp=%b", m, nrz_out, b); end
      checks++; if (data_out !== b) begin failures++; $display("[TB] FAIL nrz_data m=%0d got=%b exp=%b", m, data_out, b); end
      checks++; if (bit_clk !== (ph < 2)) begin failures++; $display("[TB] FAIL nrz_bit_clk m=%0d got=%b exp=%b", m, bit_clk, ph < 2); end
      checks++; if (frame_start !== (ph == 0 && i % 15 == 0)) begin failures++; $display("[TB] FAIL nrz_frame m=%0d got=%b exp=%b", m, frame_start, ph == 0 && i % 15 == 0); end
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL nrz_busy m=%0d got=%b exp=1", m, busy); end
    end
  endtask

  task automatic test_manchester();
    int i, ph;
    logic b, d;
    reset_dut();
    start_run(16'd3, 1'b1);
    for (int m = 0; m < 90; m++) begin
      @(negedge clk);
      i = m / 6; ph = m % 6; b = seq[i % 15];
      d = (ph < 3) ? ~b : b;
      checks++; if (data_out !== d) begin failures++; $display("[TB] FAIL manch_data m=%0d got=%b exp=%b", m, data_out, d); end
      checks++; if (bit_clk !== (ph < 3)) begin failures++; $display("[TB] FAIL manch_bit_clk m=%0d got=%b exp=%b", m, bit_clk, ph < 3); end
      checks++; if (nrz_out !== b) begin failures++; $display("[TB] FAIL manch_nrz m=%0d got=%b exp=%b", m, nrz_out, b); end
    end
  endtask

  task automatic test_rate_change();
    int i;
    logic bc;
    reset_dut();
    @(negedge clk);
    manch_en = 1'b0;
    ena      = 1'b1;
    for (int m = 0; m < 1041; m++) begin
      @(negedge clk);
      if (m < 1000)      begin i = 0;                   bc = (m < 500); end
      else if (m < 1020) begin i = 1;                   bc = ((m - 1000) < 10); end
      else if (m < 1024) begin i = 2 + (m - 1020) / 2;  bc = (m % 2 == 0); end
      else               begin i = 4 + (m - 1024) / 8;  bc = (((m - 1024) % 8) < 4); end
      checks++; if (bit_clk !== bc) begin failures++; $display("[TB] FAIL rate_bit_clk m=%0d got=%b exp=%b", m, bit_clk, bc); end
      checks++; if (nrz_out !== seq[i]) begin failures++; $display("[TB] FAIL rate_nrz m=%0d got=%b exp=%b", m, nrz_out, seq[i]); end
      case (m)
        50:      begin rate_div = 16'd50; rate_load = 1'b1; end
        100:     begin rate_div = 16'd10; rate_load = 1'b1; end
        1005:    begin rate_div = 16'd0;  rate_load = 1'b1; end
        1021:    begin rate_div = 16'd4;  rate_load = 1'b1; end
        default: rate_load = 1'b0;
      endcase
    end
    rate_load = 1'b0;
  endtask

  task automatic test_ena_gap();
    int i, ph, gap_len;
    logic b, d;
    reset_dut();
    start_run(16'd3, 1'b1);
    for (int m = 0; m < 90; m++) begin
      @(negedge clk);
      i = m / 6; ph = m % 6; b = seq[i % 15];
      d = (ph < 3) ? ~b : b;
      checks++; if (data_out !== d) begin failures++; $display("[TB] FAIL gap_data m=%0d got=%b exp=%b", m, data_out, d); end
      checks++; if (bit_clk !== (ph < 3)) begin failures++; $display("[TB] FAIL gap_bit_clk m=%0d got=%b exp=%b", m, bit_clk, ph < 3); end
      checks++; if (frame_start !== (ph == 0 && i % 15 == 0)) begin failures++; $display("[TB] FAIL gap_frame m=%0d got=%b exp=%b", m, frame_start, ph == 0 && i % 15 == 0); end
      if (m == 0 || m == 16) begin
        gap_len = (m == 0) ? 3 : 37;
        ena = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          checks++; if (data_out !== d) begin failures++; $display("[TB] FAIL hold_data m=%0d g=%0d got=%b exp=%b", m, g, data_out, d); end
          checks++; if (nrz_out !== b) begin failures++; $display("[TB] FAIL hold_nrz m=%0d g=%0d got=%b exp=%b", m, g, nrz_out, b); end
          checks++; if (bit_clk !== (ph < 3)) begin failures++; $display("[TB] FAIL hold_bit_clk m=%0d g=%0d got=%b exp=%b", m, g, bit_clk, ph < 3); end
          checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL hold_frame m=%0d g=%0d got=%b exp=0", m, g, frame_start); end
          checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_busy m=%0d g=%0d got=%b exp=1", m, g, busy); end
        end
        ena = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    start_run(16'd2, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (data_out !== 1'b0) begin failures++; $display("[TB] FAIL arst_data_out got=%b exp=0", data_out); end
    checks++; if (nrz_out !== 1'b0) begin failures++; $display("[TB] FAIL arst_nrz_out got=%b exp=0", nrz_out); end
    checks++; if (bit_clk !== 1'b0) begin failures++; $display("[TB] FAIL arst_bit_clk got=%b exp=0", bit_clk); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL arst_frame_start got=%b exp=0", frame_start); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL arst_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 502; m++) begin
      @(negedge clk);
      checks++; if (bit_clk !== (m < 500)) begin failures++; $display("[TB] FAIL arst_half m=%0d got=%b exp=%b", m, bit_clk, m < 500); end
      if (m == 0) begin
        checks++; if (frame_start !== 1'b1) begin failures++; $display("[TB] FAIL arst_frame got=%b exp=1", frame_start); end
        checks++; if (nrz_out !== seq[0]) begin failures++; $display("[TB] FAIL arst_first_bit got=%b exp=%b", nrz_out, seq[0]); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL arst_busy_after got=%b exp=1", busy); end
      end
    end
  endtask

  task automatic test_lockup();
    int i;
    logic b;
    reset_dut();
    start_run(16'd2, 1'b0);
    for (int m = 0; m < 84; m++) begin
      @(negedge clk);
      i = m / 4;
      b = (i < 6) ? seq[i] : seq[(i - 6) % 15];
      checks++; if (nrz_out !== b) begin failures++; $display("[TB] FAIL lockup_nrz m=%0d got=%b exp=%b", m, nrz_out, b); end
      if (m == 21) force dut.u_lfsr.state = 4'h0;
      if (m == 22) release dut.u_lfsr.state;
    end
  endtask

  initial begin
    test_reset();
    test_nrz_stream();
    test_manchester();
    test_rate_change();
    test_ena_gap();
    test_async_reset();
    test_lockup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mseq_manchester_tx.md
Name: mseq_manchester_tx

Overview:
Test-signal transmitter for the digital-transmission analyser chain. It generates a maximal-length pseudo-random bit stream with a Fibonacci LFSR at a programmable bit rate. The stream is optionally Manchester-encoded and emitted as a 1-bit line signal. The block is the far end of the receive path (sampling, noise reduction, period measurement, PLL clock recovery) and also exports a reference bit clock and a frame marker for bit-error comparison.

Parameters:
LFSR_WIDTH, 8, LFSR length; m-sequence period is 2^LFSR_WIDTH-1.
POLY, 8'hB8, tap mask; bit i set means state bit i feeds the XOR.
SEED, 8'h01, reset and recovery state; must be non-zero.
DIV_WIDTH, 16, width of the rate divider.
DEFAULT_HALF, 500, half-bit length in clocks after reset.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ena  in  1  run enable; low freezes the block
rate_div  in  DIV_WIDTH  requested half-bit length in clocks
rate_load  in  1  1-cycle strobe that captures rate_div
manch_en  in  1  1 = Manchester output, 0 = NRZ output; sampled at bit boundaries
data_out  out  1  line signal
nrz_out  out  1  current un-encoded bit
bit_clk  out  1  high during the first half of each bit, low during the second
frame_start  out  1  1-cycle pulse on the first bit of each m-sequence period
busy  out  1  high while a bit is in flight

Behaviour:
- Reset (async, any time):
  - lfsr=SEED, half_len=DEFAULT_HALF, pending rate cleared, half_cnt=0, phase=IDLE.
  - data_out, nrz_out, bit_clk, frame_start and busy all 0.
- States:
  - IDLE: waits for ena=1.
  - FIRST: first half of a bit.
  - SECOND: second half of a bit.
- Bit load, on entering FIRST from IDLE or from the end of SECOND:
  - cur = lfsr[LFSR_WIDTH-1].
  - lfsr <= {lfsr[W-2:0], ^(lfsr & POLY)}.
  - nrz_out <= cur; bit_clk <= 1; busy <= 1; manch_en latched into mode.
  - frame_start <= 1 for that one cycle if lfsr == SEED before the shift.
- Line levels, all outputs registered, no combinational path from inputs:
  - Manchester (IEEE 802.3): bit 1 = low then high; bit 0 = high then low.
  - So data_out = ~cur in FIRST and cur in SECOND.
  - NRZ: data_out = cur in both halves.
- Timing:
  - half_cnt counts 0..half_len-1 while ena=1.
  - At half_len-1 in FIRST: go to SECOND, bit_clk <= 0, data_out updates.
  - At half_len-1 in SECOND: load the next bit back-to-back with no gap.
  - Bit period = 2*half_len clocks.
  - The first bit appears on the edge after ena is first seen high in IDLE.
- Rate change:
  - rate_load captures rate_div into pending; pending is applied at the next bit load, never mid-bit.
  - rate_div=0 is clamped to 1, giving a bit period of 2 clocks.
  - If two loads arrive before a boundary, the last one wins.
  - A rate_load on the same cycle as a bit load is applied at the following boundary.
- ena low:
  - half_cnt, lfsr and phase freeze; all outputs hold their values.
  - frame_start is forced to 0.
  - Resume continues exactly where it stopped, with no bit lost or repeated.
- Lock-up guard: if lfsr == 0 (only reachable through an upset), the next bit load uses SEED in place of the state.
- Wrap-around: the LFSR repeats every 2^W-1 bits, and frame_start recurs with exactly that period.

Decomposition:
- Shared package holds:
  - MANCH_ONE_FIRST = 1'b0 (first-half level for bit 1);
  - default POLY / SEED per width (4: 4'h9; 8: 8'hB8; 15: 15'h6000);
  - phase enum {IDLE, FIRST, SECOND}.
- One sub-module, lfsr_gen: parameters W, POLY, SEED; ports clk, rst, step, state, out_bit. It contains the shift and the zero-state guard.
- The top contains the divider, the FSM, the encoder and the rate shadow register.

Test Plan:
1. LFSR_WIDTH=4, POLY=4'h9, SEED=4'h1, half_len=2, manch_en=0, ena=1 -> nrz_out over 15 bits = 0,0,0,1,1,1,1,0,1,0,1,1,0,0,1, then repeats. frame_start pulses every 60 clocks, on bits 0 and 15.
2. Same stream with manch_en=1, half_len=3 -> per bit, data_out is 3 clocks of ~b then 3 clocks of b; first bit 0 gives 1,1,1,0,0,0. bit_clk is a 6-clock square wave.
3. Default params, rate_div=10 strobed mid-bit while half_len=500 -> the current bit completes at 1000 clocks; the next bit is 20 clocks long. rate_div=0 gives a 2-clock bit.
4. ena dropped for 37 cycles mid-SECOND -> all outputs constant during the gap; the remaining half length and the sequence continue unchanged compared with a golden model run with no gap.
5. rst asserted asynchronously mid-bit, between clock edges -> all outputs 0 immediately. After release with ena=1, the sequence restarts from SEED with frame_start on the first bit.
6. lfsr forced to 0 by a testbench deposit -> the next bit is taken from SEED and the stream never sticks at constant 0.
